hes_stream_cipher_core: RTL and testbench

//  Multi-lane, streaming successor of the byte-array stream cipher.

---
 rtl/hes_stream_cipher_core.sv | 175 +++++++++++++++++
 tb/tb_hes_stream_cipher_core.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hes_stream_cipher_core.sv
// Multi-lane ciphertext-feedback stream cipher with valid/ready on both sides.
// Optional sticky sequencing check enabled by defining HES_SEQ_CHECK_EN.
module hes_stream_cipher_core #(
    parameter int LANES     = 4,
    parameter int KEY_BYTES = 2,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic                   is_ciphertext,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [8*LANES-1:0]     s_data,
    input  logic [LANES-1:0]       s_keep,
    input  logic                   s_first,
    input  logic                   s_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [8*LANES-1:0]     m_data,
    output logic [LANES-1:0]       m_keep,
    output logic                   m_last,
    output logic                   seq_err,
    output logic                   dbg_state
);

    localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    // AES S-box: multiplicative inverse as x^254 (product of x^2..x^128), then the affine map.
    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] inv;
        p   = x;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       n_q, n_d;
    logic [7:0]             fb_q, fb_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;
    logic                   mode_q, mode_d;
    logic                   m_valid_q, m_valid_d;
    logic [8*LANES-1:0]     m_data_q, m_data_d;
    logic [LANES-1:0]       m_keep_q, m_keep_d;
    logic                   m_last_q, m_last_d;
    logic                   seq_err_q, seq_err_d;

    logic                   accept, drop, seq_hit;
    logic [8*KEY_BYTES-1:0] key_v;
    logic                   mode_v;
    logic [CNT_W-1:0]       n_v;
    logic [7:0]             fb_v, in_b, key_b, out_b;
    logic [8*LANES-1:0]     out_v;
    int                     kidx;

    // Handshake: a beat transfers on s_valid & s_ready and a result on m_valid & m_ready;
    // the single output register may be refilled in the same cycle it drains.
    assign s_ready = !m_valid_q | m_ready;

    always_comb begin
        accept    = s_valid & s_ready;
        drop      = 1'b0;
        seq_hit   = 1'b0;
        state_d   = state_q;
        n_d       = n_q;
        fb_d      = fb_q;
        key_d     = key_q;
        mode_d    = mode_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;
        m_last_d  = m_last_q;
        key_v     = s_first ? key : key_q;
        mode_v    = s_first ? is_ciphertext : mode_q;
        n_v       = s_first ? '0 : n_q;
        fb_v      = s_first ? 8'h00 : fb_q;
        out_v     = '0;
        in_b      = 8'h00;
        key_b     = 8'h00;
        out_b     = 8'h00;
        kidx      = 0;

        for (int i = 0; i < LANES; i++) begin
            if (s_keep[i]) begin
                kidx  = (KEY_BYTES > 1) ? int'(n_v[KIDX_W-1:0]) : 0;
                key_b = key_v[8*kidx +: 8];
                in_b  = s_data[8*i +: 8];
                out_b = in_b ^ aes_sbox(key_b ^ n_v[7:0] ^ fb_v);
                out_v[8*i +: 8] = out_b;
                fb_v  = mode_v ? in_b : out_b;
                n_v   = n_v + CNT_W'(1);
            end
        end

`ifdef HES_SEQ_CHECK_EN
        seq_hit   = accept & ((!s_first & (state_q == IDLE)) | (s_first & (state_q == ACTIVE)));
        drop      = accept & !s_first & (state_q == IDLE);
        seq_err_d = seq_err_q | seq_hit;
`else
        seq_err_d = 1'b0;
`endif

        if (m_valid_q & m_ready) m_valid_d = 1'b0;

        if (accept & !drop) begin
            m_valid_d = 1'b1;
            m_data_d  = out_v;
            m_keep_d  = s_keep;
            m_last_d  = s_last;
            n_d       = n_v;
            fb_d      = fb_v;
            if (s_first) begin
                key_d   = key;
                mode_d  = is_ciphertext;
                state_d = s_last ? IDLE : ACTIVE;
            end else if (s_last) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            n_q       <= '0;
            fb_q      <= 8'h00;
            key_q     <= '0;
            mode_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_last_q  <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            fb_q      <= fb_d;
            key_q     <= key_d;
            mode_q    <= mode_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
            m_last_q  <= m_last_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_keep    = m_keep_q;
    assign m_last    = m_last_q;
    assign seq_err   = seq_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_hes_stream_cipher_core.sv
// Bench for hes_stream_cipher_core: directed cases plus random messages, scoreboard-checked
// against a byte-level reference model with a brute-force S-box.
module tb_hes_stream_cipher_core;
  localparam int LANES     = 4;
  localparam int KEY_BYTES = 2;
  localparam int CNT_W     = 16;

  logic        clk;
  logic        rst_n;
  logic [15:0] key;
  logic        is_ciphertext;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic        s_first;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic        seq_err;
  logic        dbg_state;

  hes_stream_cipher_core #(.LANES(LANES), .KEY_BYTES(KEY_BYTES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .is_ciphertext(is_ciphertext),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_keep(s_keep),
    .s_first(s_first), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .seq_err(seq_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          failures;
  logic [36:0] exp_q[$];
  logic [7:0]  sbox_t[256];
  logic [15:0] mkey;
  logic        mmode;
  int          mn;
  logic [7:0]  mfb;
  logic [36:0] last_exp;
  int          stall_cnt;
  bit          rand_bp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0]  inv;
    logic [7:0]  s;
    logic [15:0] t;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int a = 1; a < 256; a++)
        if (tb_gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(a);
      s = 8'h63;
      for (int k = 0; k < 5; k++) begin
        t = {inv, inv} << k;
        s ^= t[15:8];
      end
      sbox_t[b] = s;
    end
  endtask

  task automatic model_reset();
    mkey  = 16'h0;
    mmode = 1'b0;
    mn    = 0;
    mfb   = 8'h00;
  endtask

  // One beat of the cipher at byte level: keystream from key byte, counter and previous ciphertext.
  function automatic logic [36:0] model_beat(input bit first, input bit last, input logic [3:0] keep,
                                             input logic [31:0] din, input logic [15:0] k, input bit mode);
    logic [31:0] dout;
    logic [7:0]  b;
    logic [7:0]  kb;
    logic [7:0]  o;
    logic [7:0]  nlo;
    dout = 32'h0;
    if (first) begin
      mkey  = k;
      mmode = mode;
      mn    = 0;
      mfb   = 8'h00;
    end
    for (int i = 0; i < LANES; i++) begin
      if (keep[i]) begin
        b   = din[8*i +: 8];
        kb  = mkey[8*(mn % KEY_BYTES) +: 8];
        nlo = 8'(mn % 256);
        o   = b ^ sbox_t[kb ^ nlo ^ mfb];
        dout[8*i +: 8] = o;
        mfb = mmode ? b : o;
        mn  = (mn + 1) % (1 << CNT_W);
      end
    end
    return {last, keep, dout};
  endfunction

  // driver: present a beat, push the expected result at the cycle it is accepted
  task automatic send(input bit first, input bit last, input logic [3:0] keep, input logic [31:0] din,
                      input logic [15:0] k, input bit mode, input bit expect_out);
    bit done;
    done          = 1'b0;
    s_valid       = 1'b1;
    s_first       = first;
    s_last        = last;
    s_keep        = keep;
    s_data        = din;
    key           = k;
    is_ciphertext = mode;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (s_ready) begin
        if (expect_out) begin
          last_exp = model_beat(first, last, keep, din, k, mode);
          exp_q.push_back(last_exp);
        end
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: s_ready stayed 0 expected 1");
    end
    s_valid = 1'b0;
  endtask

  // downstream ready: random backpressure or a forced stall window
  always @(posedge clk) begin
    #1;
    if (stall_cnt > 0) begin
      m_ready = 1'b0;
      stall_cnt--;
    end else begin
      m_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && m_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {27'h0, m_last, m_keep, m_data}, 64'h0);
      end else begin
        chk("output_beat", {27'h0, m_last, m_keep, m_data}, {27'h0, exp_q[0]});
        if (m_ready) void'(exp_q.pop_front());
        else chk("s_ready_in_stall", 64'(s_ready), 64'h0);
      end
`ifndef HES_SEQ_CHECK_EN
      chk("seq_err_tied", 64'(seq_err), 64'h0);
`endif
    end
  end

  logic [31:0] msg_data[8];
  logic [15:0] rk;
  bit          rm;
  int          nb;
  logic [3:0]  lk;

  initial begin
    checks        = 0;
    failures      = 0;
    stall_cnt     = 0;
    rand_bp       = 1'b0;
    rst_n         = 1'b0;
    m_ready       = 1'b1;
    s_valid       = 1'b0;
    s_first       = 1'b0;
    s_last        = 1'b0;
    s_keep        = 4'h0;
    s_data        = 32'h0;
    key           = 16'h0;
    is_ciphertext = 1'b0;
    model_reset();
    build_sbox();
    #12;
    chk("rst_m_valid", 64'(m_valid), 64'h0);
    chk("rst_m_data", 64'(m_data), 64'h0);
    chk("rst_m_keep", 64'(m_keep), 64'h0);
    chk("rst_m_last", 64'(m_last), 64'h0);
    chk("rst_seq_err", 64'(seq_err), 64'h0);
    chk("rst_s_ready", 64'(s_ready), 64'h1);
    chk("rst_state", 64'(dbg_state), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef HES_SEQ_CHECK_EN
    send(1'b0, 1'b1, 4'hF, $urandom, 16'h1234, 1'b0, 1'b0);
    @(negedge clk);
    chk("seq_err_set", 64'(seq_err), 64'h1);
    chk("seq_drop_no_valid", 64'(m_valid), 64'h0);
`endif

    // key 0, data 0, encrypt: lanes 0/1 are 63, AA with one-cycle latency
    send(1'b1, 1'b1, 4'hF, 32'h0, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    chk("lat_m_valid", 64'(m_valid), 64'h1);
    chk("kat_lanes01", 64'(m_data[15:0]), 64'hAA63);
    @(posedge clk);
    #1;

    // round trip: decrypt the ciphertext just produced
    send(1'b1, 1'b1, 4'hF, last_exp[31:0], 16'h0000, 1'b1, 1'b1);
    @(negedge clk);
    chk("round_trip", 64'(m_data), 64'h0);
    @(posedge clk);
    #1;

    // 8-beat message with a 5-cycle stall, then the same message unstalled
    for (int i = 0; i < 8; i++) msg_data[i] = $urandom;
    rk = 16'($urandom);
    fork
      begin
        for (int b = 0; b < 8; b++) send(b == 0, b == 7, 4'hF, msg_data[b], rk, 1'b0, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        stall_cnt = 5;
      end
    join
    for (int b = 0; b < 8; b++) send(b == 0, b == 7, 4'hF, msg_data[b], rk, 1'b0, 1'b1);

    // partial last beat, then a fresh key-0 message
    send(1'b1, 1'b0, 4'hF, $urandom, 16'($urandom), 1'b0, 1'b1);
    send(1'b0, 1'b1, 4'b0011, $urandom, 16'h0, 1'b0, 1'b1);
    @(negedge clk);
    chk("partial_keep", 64'(m_keep), 64'h3);
    chk("partial_last", 64'(m_last), 64'h1);
    chk("partial_upper", 64'(m_data[31:16]), 64'h0);
    @(posedge clk);
    #1;
    send(1'b1, 1'b1, 4'hF, 32'h0, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    chk("after_partial_lane0", 64'(m_data[7:0]), 64'h63);
    @(posedge clk);
    #1;

    // asynchronous reset during beat 3 of a 6-beat message
    rk = 16'($urandom);
    for (int b = 0; b < 3; b++) send(b == 0, 1'b0, 4'hF, $urandom, rk, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_m_valid", 64'(m_valid), 64'h0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(1'b1, 1'b1, 4'hF, 32'h0, 16'h0000, 1'b0, 1'b1);
    @(negedge clk);
    chk("post_rst_kat", 64'(m_data[15:0]), 64'hAA63);
    @(posedge clk);
    #1;

`ifndef HES_SEQ_CHECK_EN
    // continuation in IDLE uses the retained key/mode/counter/feedback
    send(1'b0, 1'b1, 4'hF, $urandom, 16'($urandom), 1'b1, 1'b1);
`endif
    // restart while a message is active
    send(1'b1, 1'b0, 4'hF, $urandom, 16'($urandom), 1'b0, 1'b1);
    send(1'b1, 1'b1, 4'hF, $urandom, 16'($urandom), 1'b1, 1'b1);

    // random messages under random backpressure
    rand_bp = 1'b1;
    for (int m = 0; m < 25; m++) begin
      rk = 16'($urandom);
      rm = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 6);
      lk = 4'((1 << $urandom_range(1, 4)) - 1);
      for (int b = 0; b < nb; b++)
        send(b == 0, b == nb - 1, (b == nb - 1) ? lk : 4'hF, $urandom, rk, rm, 1'b1);
    end

    for (int c = 0; c < 1000 && exp_q.size() != 0; c++) @(posedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'h0);
`ifdef HES_SEQ_CHECK_EN
    chk("seq_err_sticky", 64'(seq_err), 64'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
